// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared FFT controller types, defaults and helper functions.
//            The BITREV state exists only when FFT_BITREV_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_AWL_DEF    = 11;
    localparam int FFT_BF_LAT_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_FIN    = 3'd3
`ifdef FFT_BITREV_EN
        ,S_BITREV = 3'd4
`endif
    } fft_state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Reverse the low l bits of v; bits above l come back zero.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input logic [3:0] l);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[15-i] = v[i];
        end
        return r >> (5'd16 - {1'b0, l});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_iter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_iter_ctrl_if
// Purpose  : Control, RAM-address and twiddle bundle of the FFT controller.
// Revision : 1.0  initial release
// ============================================================================
interface fft_iter_ctrl_if
    import fft_pkg::*;
#(
    parameter int AWL = FFT_AWL_DEF
);
    logic           EN;
    logic           START;
    logic [3:0]     i_LOG2N;
    logic           i_INV;
    logic [AWL-1:0] o_RD_A_ADDR;
    logic [AWL-1:0] o_RD_B_ADDR;
    logic           o_RD_EN;
    logic [AWL-2:0] o_TW_ADDR;
    logic           o_TW_CONJ;
    logic [AWL-1:0] o_WR_A_ADDR;
    logic [AWL-1:0] o_WR_B_ADDR;
    logic           o_WR_EN;
    logic [3:0]     o_STAGE;
    logic           o_RAM_BLOCK;
    logic           o_BUSY;
    logic           o_DONE;
    logic [AWL-1:0] o_BR_ADDR;
    logic           o_BR_VALID;

    modport master (
        output EN, START, i_LOG2N, i_INV,
        input  o_RD_A_ADDR, o_RD_B_ADDR, o_RD_EN, o_TW_ADDR, o_TW_CONJ,
               o_WR_A_ADDR, o_WR_B_ADDR, o_WR_EN, o_STAGE, o_RAM_BLOCK,
               o_BUSY, o_DONE, o_BR_ADDR, o_BR_VALID
    );

    modport slave (
        input  EN, START, i_LOG2N, i_INV,
        output o_RD_A_ADDR, o_RD_B_ADDR, o_RD_EN, o_TW_ADDR, o_TW_CONJ,
               o_WR_A_ADDR, o_WR_B_ADDR, o_WR_EN, o_STAGE, o_RAM_BLOCK,
               o_BUSY, o_DONE, o_BR_ADDR, o_BR_VALID
    );
endinterface
`default_nettype wire

// File: rtl/fft_iter_ctrl_addr_delay.sv
`default_nettype none
// ============================================================================
// Module   : fft_addr_delay
// Purpose  : Enabled shift register aligning write-back {en, A, B} with the
//            butterfly datapath latency.
// Revision : 1.0  initial release
// ============================================================================
module fft_addr_delay #(
    parameter int W     = 23,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en_i) begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/fft_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_iter_ctrl
// Purpose  : Radix-2 in-place FFT address/twiddle sequencer with drain between
//            stages. Define FFT_BITREV_EN to add the bit-reversed readout.
// Revision : 1.0  initial release
// ============================================================================
module fft_iter_ctrl
    import fft_pkg::*;
#(
    parameter int AWL    = FFT_AWL_DEF,
    parameter int BF_LAT = FFT_BF_LAT_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    fft_iter_ctrl_if.slave bus
);
    localparam int c_dw = (clog2(BF_LAT + 1) < 1) ? 1 : clog2(BF_LAT + 1);
    localparam int c_tw = AWL - 1;
    localparam logic [c_dw-1:0] c_dlast = c_dw'(BF_LAT - 1);
    localparam logic [AWL-1:0]  c_one   = AWL'(1);

    fft_state_t      state_q;
    logic [3:0]      l_q, stage_q;
    logic            inv_q, busy_q, done_q, rd_en_q;
    logic [AWL-1:0]  k_q, rd_a_q, rd_b_q;
    logic [c_tw-1:0] tw_q;
    logic [c_dw-1:0] dcnt_q;
    logic [2*AWL:0]  w_wr;

    logic [3:0]      w_l;
    logic [AWL-1:0]  w_half_m1, w_k_nxt, w_h, w_j, w_a, w_b, w_h2;
    logic [c_tw-1:0] w_tw;

    always_comb begin
        w_l = bus.i_LOG2N;
        if (bus.i_LOG2N == 4'd0) begin
            w_l = 4'd1;
        end else if (int'(bus.i_LOG2N) > AWL) begin
            w_l = 4'(AWL);
        end
    end

    // Addresses of the butterfly that follows k_q in the current stage.
    assign w_half_m1 = (c_one << (l_q - 4'd1)) - c_one;
    assign w_k_nxt   = k_q + c_one;
    assign w_h       = c_one << stage_q;
    assign w_j       = w_k_nxt & (w_h - c_one);
    assign w_a       = ((w_k_nxt >> stage_q) << (stage_q + 4'd1)) | w_j;
    assign w_b       = w_a | w_h;
    assign w_tw      = c_tw'(w_j << (4'(AWL - 1) - stage_q));
    assign w_h2      = c_one << (stage_q + 4'd1);

`ifdef FFT_BITREV_EN
    logic [AWL-1:0] n_q, br_addr_q, w_n_nxt, w_nm1, w_br;
    logic           br_valid_q;
    assign w_n_nxt = n_q + c_one;
    assign w_nm1   = (c_one << l_q) - c_one;
    assign w_br    = AWL'(bitrev(16'(w_n_nxt), l_q));
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            k_q     <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            dcnt_q  <= '0;
`ifdef FFT_BITREV_EN
            n_q        <= '0;
            br_addr_q  <= '0;
            br_valid_q <= 1'b0;
`endif
        end else if (bus.EN) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        state_q <= S_RUN;
                        l_q     <= w_l;
                        inv_q   <= bus.i_INV;
                        busy_q  <= 1'b1;
                        stage_q <= '0;
                        k_q     <= '0;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= '0;
                        rd_b_q  <= c_one;
                        tw_q    <= '0;
                    end
                end
                S_RUN: begin
                    if (k_q == w_half_m1) begin
                        state_q <= S_DRAIN;
                        dcnt_q  <= '0;
                        rd_en_q <= 1'b0;
                        rd_a_q  <= '0;
                        rd_b_q  <= '0;
                        tw_q    <= '0;
                    end else begin
                        k_q    <= w_k_nxt;
                        rd_a_q <= w_a;
                        rd_b_q <= w_b;
                        tw_q   <= w_tw;
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q != c_dlast) begin
                        dcnt_q <= dcnt_q + c_dw'(1);
                    end else if (stage_q == l_q - 4'd1) begin
`ifdef FFT_BITREV_EN
                        state_q    <= S_BITREV;
                        n_q        <= '0;
                        br_addr_q  <= '0;
                        br_valid_q <= 1'b1;
`else
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= S_RUN;
                        stage_q <= stage_q + 4'd1;
                        k_q     <= '0;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= '0;
                        rd_b_q  <= w_h2;
                        tw_q    <= '0;
                    end
                end
`ifdef FFT_BITREV_EN
                S_BITREV: begin
                    if (n_q == w_nm1) begin
                        state_q    <= S_FIN;
                        br_valid_q <= 1'b0;
                        br_addr_q  <= '0;
                        done_q     <= 1'b1;
                    end else begin
                        n_q       <= w_n_nxt;
                        br_addr_q <= w_br;
                    end
                end
`endif
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    fft_addr_delay #(
        .W     (2*AWL + 1),
        .DEPTH (BF_LAT)
    ) u_delay (
        .clk_i  (CLK),
        .rst_ni (RST),
        .en_i   (bus.EN),
        .d_i    ({rd_en_q, rd_a_q, rd_b_q}),
        .q_o    (w_wr)
    );

    assign bus.o_RD_A_ADDR = rd_a_q;
    assign bus.o_RD_B_ADDR = rd_b_q;
    assign bus.o_RD_EN     = rd_en_q;
    assign bus.o_TW_ADDR   = tw_q;
    assign bus.o_TW_CONJ   = inv_q;
    assign bus.o_WR_EN     = w_wr[2*AWL];
    assign bus.o_WR_A_ADDR = w_wr[2*AWL-1:AWL];
    assign bus.o_WR_B_ADDR = w_wr[AWL-1:0];
    assign bus.o_STAGE     = stage_q;
    assign bus.o_RAM_BLOCK = busy_q;
    assign bus.o_BUSY      = busy_q;
    assign bus.o_DONE      = done_q;
`ifdef FFT_BITREV_EN
    assign bus.o_BR_ADDR   = br_addr_q;
    assign bus.o_BR_VALID  = br_valid_q;
`else
    assign bus.o_BR_ADDR   = '0;
    assign bus.o_BR_VALID  = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fft_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_iter_ctrl
// Purpose  : Self-checking bench for fft_iter_ctrl (AWL=11, BF_LAT=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_iter_ctrl;
    import fft_pkg::*;

    localparam int AWL = 11;
    localparam int BF  = 4;

    typedef struct {
        logic [3:0] log2n;
        logic       inv;
        int         exp_cycles;
        int         exp_max;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
`ifdef FFT_BITREV_EN
    localparam int BR8 = 8;
`else
    localparam int BR8 = 0;
`endif

    always #5 CLK = ~CLK;

    fft_iter_ctrl_if #(.AWL(AWL)) bus ();

    fft_iter_ctrl #(.AWL(AWL), .BF_LAT(BF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ones_out();
        return $countones({bus.o_RD_A_ADDR, bus.o_RD_B_ADDR, bus.o_RD_EN, bus.o_TW_ADDR,
                           bus.o_TW_CONJ, bus.o_WR_A_ADDR, bus.o_WR_B_ADDR, bus.o_WR_EN,
                           bus.o_STAGE, bus.o_RAM_BLOCK, bus.o_BUSY, bus.o_DONE,
                           bus.o_BR_ADDR, bus.o_BR_VALID});
    endfunction

`ifdef FFT_BITREV_EN
    function automatic int rev(input int v, input int l);
        int r = 0;
        for (int i = 0; i < l; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction
`endif

    // Expected read-side output at cycle c (cycle 0 = START sampled).
    function automatic void mrd(input int c, input int L, input int N, output int en,
                                output int a, output int b, output int tw, output int st);
        int P, ph, h, j;
        P = N / 2 + BF;
        en = 0; a = 0; b = 0; tw = 0; st = 0;
        if (c >= 1 && c <= L * P) begin
            st = (c - 1) / P;
            ph = (c - 1) % P;
            if (ph < N / 2) begin
                h  = 1 << st;
                j  = ph % h;
                en = 1;
                a  = (ph / h) * 2 * h + j;
                b  = a + h;
                tw = j * (1 << (AWL - 1 - st));
            end
        end
    endfunction

    task automatic start_tx(input logic [3:0] l2, input logic inv);
        @(negedge CLK);
        bus.START   = 1'b1;
        bus.i_LOG2N = l2;
        bus.i_INV   = inv;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int L, N, P, T, dc, ndone, mx;
        int e_seq, e_en, e_wr, e_busy, e_stage, e_conj, e_br;
        int en, a, b, tw, st, wen, wa, wb, wtw, wst;
        bit bsy;
        L = (v.log2n == 4'd0) ? 1 : ((int'(v.log2n) > AWL) ? AWL : int'(v.log2n));
        N = 1 << L;
        P = N / 2 + BF;
        T = v.exp_cycles;
`ifdef FFT_BITREV_EN
        T += N;
`endif
        dc = -1; ndone = 0; mx = 0;
        e_seq = 0; e_en = 0; e_wr = 0; e_busy = 0; e_stage = 0; e_conj = 0; e_br = 0;
        start_tx(v.log2n, v.inv);
        for (int c = 1; c <= T + 20; c++) begin
            @(negedge CLK);
            bus.START = 1'b0;
            mrd(c, L, N, en, a, b, tw, st);
            if (c <= L * P && int'(bus.o_STAGE) != st) e_stage++;
            if (bus.o_RD_EN !== 1'(en)) e_en++;
            else if (en == 1) begin
                if (int'(bus.o_RD_A_ADDR) != a || int'(bus.o_RD_B_ADDR) != b ||
                    int'(bus.o_TW_ADDR) != tw) e_seq++;
                if (int'(bus.o_RD_B_ADDR) > mx) mx = int'(bus.o_RD_B_ADDR);
                if (int'(bus.o_RD_A_ADDR) > mx) mx = int'(bus.o_RD_A_ADDR);
            end
            mrd(c - BF, L, N, wen, wa, wb, wtw, wst);
            if (bus.o_WR_EN !== 1'(wen)) e_wr++;
            else if (wen == 1 && (int'(bus.o_WR_A_ADDR) != wa || int'(bus.o_WR_B_ADDR) != wb)) e_wr++;
            bsy = (c <= T);
            if (bus.o_BUSY !== bsy || bus.o_RAM_BLOCK !== bsy) e_busy++;
            if (bsy && bus.o_TW_CONJ !== v.inv) e_conj++;
`ifdef FFT_BITREV_EN
            bsy = (c > L * P && c <= L * P + N);
            if (bus.o_BR_VALID !== bsy) e_br++;
            else if (bsy && int'(bus.o_BR_ADDR) != rev(c - L * P - 1, L)) e_br++;
`else
            if (bus.o_BR_VALID !== 1'b0 || bus.o_BR_ADDR != '0) e_br++;
`endif
            if (bus.o_DONE === 1'b1) begin
                ndone++;
                if (dc < 0) dc = c;
            end
        end
        check($sformatf("v%0d_done_cycle", idx), dc, T);
        check($sformatf("v%0d_done_count", idx), ndone, 1);
        check($sformatf("v%0d_rd_seq_err", idx), e_seq, 0);
        check($sformatf("v%0d_rd_en_err", idx), e_en, 0);
        check($sformatf("v%0d_wr_err", idx), e_wr, 0);
        check($sformatf("v%0d_busy_err", idx), e_busy, 0);
        check($sformatf("v%0d_stage_err", idx), e_stage, 0);
        check($sformatf("v%0d_conj_err", idx), e_conj, 0);
        check($sformatf("v%0d_bitrev_err", idx), e_br, 0);
        check($sformatf("v%0d_max_addr", idx), mx, v.exp_max);
    endtask

    vec_t vecs[6];

    initial begin
        int dc, ndone, bsy_after, bsy_cnt;
        vecs[0] = '{4'd3,  1'b0, 25,    7};
        vecs[1] = '{4'd3,  1'b1, 25,    7};
        vecs[2] = '{4'd0,  1'b0, 6,     1};
        vecs[3] = '{4'd2,  1'b1, 13,    3};
        vecs[4] = '{4'd5,  1'b0, 101,   31};
        vecs[5] = '{4'd15, 1'b1, 11309, 2047};

        bus.EN = 1'b1; bus.START = 1'b0; bus.i_LOG2N = 4'd0; bus.i_INV = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_outputs_zero", ones_out(), 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_outputs_zero", ones_out(), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // START during RUN and during FIN must not restart.
        dc = -1; ndone = 0; bsy_after = -1;
        start_tx(4'd3, 1'b0);
        for (int c = 1; c <= 45; c++) begin
            @(negedge CLK);
            bus.START = (c == 10);
            if (c == dc + 1) bsy_after = int'(bus.o_BUSY);
            if (bus.o_DONE === 1'b1) begin
                ndone++;
                if (dc < 0) begin
                    dc = c;
                    bus.START = 1'b1;
                end
            end
        end
        bus.START = 1'b0;
        check("restart_done_cycle", dc, 25 + BR8);
        check("restart_done_count", ndone, 1);
        check("start_in_fin_busy", bsy_after, 0);
        repeat (3) @(negedge CLK);

        // EN held low for five cycles stretches completion by five.
        dc = -1;
        start_tx(4'd3, 1'b0);
        for (int c = 1; c <= 50; c++) begin
            @(negedge CLK);
            bus.START = 1'b0;
            if (c == 6) bus.EN = 1'b0;
            if (c == 11) bus.EN = 1'b1;
            if (bus.o_DONE === 1'b1 && dc < 0) dc = c;
        end
        check("stall_done_cycle", dc, 30 + BR8);

        // Reset in the middle of RUN.
        start_tx(4'd3, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            bus.START = 1'b0;
        end
        RST = 1'b0;
        #1;
        check("midrun_reset_outputs", ones_out(), 0);
        @(negedge CLK);
        RST = 1'b1;
        bsy_cnt = 0; ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (bus.o_BUSY !== 1'b0) bsy_cnt++;
            if (bus.o_DONE !== 1'b0) ndone++;
        end
        check("post_reset_busy", bsy_cnt, 0);
        check("post_reset_done", ndone, 0);
        run_vec(vecs[0], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
